// File: rtl/bias_prefetch_loader.sv
// bias_prefetch_loader: per-OA-tile bias provider for the matmul datapath.
// Prefetches SIZE-lane bias vectors over a read-only ICB master into a small
// FIFO of NUM_BUF slots, and presents one vector on data_out for the first
// partial sum of each OA tile (zeros for every later partial sum).
// Optional feature macro: BIAS_PREFETCH_PERF_EN adds saturating perf counters
// (perf_fetch_cycles, perf_underflow_cnt); without it those ports do not exist.

package bias_prefetch_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        read;
    logic [7:0]  len;
    logic [1:0]  size;
  } icb_ext_cmd_m_t;

  typedef struct packed {
    logic cmd_ready;
  } icb_ext_cmd_s_t;

  typedef struct packed {
    logic        w_valid;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } icb_ext_wr_m_t;

  typedef struct packed {
    logic w_ready;
  } icb_ext_wr_s_t;

  typedef struct packed {
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;
  } icb_ext_rsp_s_t;

  typedef struct packed {
    logic rsp_ready;
  } icb_ext_rsp_m_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CMD,
    ST_RSP,
    ST_DONE,
    ST_DRAIN
  } fetch_state_e;

endpackage

module bias_prefetch_loader
  import bias_prefetch_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int NUM_BUF    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_cfg,
  input  logic [REG_WIDTH-1:0]  bias_base,
  input  logic [REG_WIDTH-1:0]  m,
  output logic                  load_bias_req,
  input  logic                  load_bias_granted,
  output icb_ext_cmd_m_t        icb_cmd_m,
  input  icb_ext_cmd_s_t        icb_cmd_s,
  output icb_ext_wr_m_t         icb_wr_m,
  input  icb_ext_wr_s_t         icb_wr_s,
  input  icb_ext_rsp_s_t        icb_rsp_s,
  output icb_ext_rsp_m_t        icb_rsp_m,
  input  logic                  tile_calc_start,
  input  logic                  partial_sum_calc_over,
  input  logic                  tile_calc_over,
  output logic                  bias_valid,
  output logic                  bias_err,
  output logic [DATA_WIDTH-1:0] data_out [SIZE]
`ifdef BIAS_PREFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cycles,
  output logic [15:0]           perf_underflow_cnt
`endif
);

  localparam int PTR_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int E_W   = (SIZE > 1) ? $clog2(SIZE) : 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fetch_state_e           state, state_next;

  logic                   need;
  logic                   cfg_done;
  logic [REG_WIDTH-1:0]   base_q;
  logic [REG_WIDTH-1:0]   m_q;
  logic [REG_WIDTH-1:0]   ntiles;

  logic [REG_WIDTH-1:0]   ft;
  logic [E_W-1:0]         e;
  logic [PTR_W-1:0]       wp, rp;
  logic [NUM_BUF-1:0]     slot_full;
  logic [DATA_WIDTH-1:0]  slot_mem [NUM_BUF][SIZE];

  logic                   start_d, over_d, first_flag;

  // ---------------------------------------------------------------------------
  // Derived signals
  // ---------------------------------------------------------------------------
  logic [REG_WIDTH-1:0]   ch_idx;
  logic [REG_WIDTH:0]     m_round;
  logic [REG_WIDTH-1:0]   ntiles_calc;
  logic                   lane_skip, last_lane;
  logic                   cmd_valid, cmd_fire, rsp_fire;
  logic                   start_edge, over_edge;
  logic                   head_full, free_slot;
  logic                   pop, underflow, fill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_BUF - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ch_idx      = ft * REG_WIDTH'(SIZE) + REG_WIDTH'(e);
  assign m_round     = {1'b0, m} + (REG_WIDTH + 1)'(SIZE - 1);
  assign ntiles_calc = REG_WIDTH'(m_round / (REG_WIDTH + 1)'(SIZE));
  assign lane_skip   = (ch_idx >= m_q);
  assign last_lane   = (e == E_W'(SIZE - 1));
  assign cmd_fire    = cmd_valid && icb_cmd_s.cmd_ready;
  assign rsp_fire    = icb_rsp_s.rsp_valid;
  assign start_edge  = tile_calc_start && !start_d;
  assign over_edge   = tile_calc_over && !over_d;
  assign head_full   = slot_full[rp];
  assign free_slot   = !slot_full[wp];
  assign pop         = start_edge && first_flag && need && head_full && !init_cfg;
  assign underflow   = start_edge && first_flag && need && !head_full && !init_cfg;
  assign fill        = (state == ST_DONE) && !init_cfg;

  assign bias_valid  = cfg_done && (!need || head_full);

  // Read-only master: write channel idle, responses always accepted.
  assign icb_wr_m    = '0;
  assign icb_rsp_m   = '{rsp_ready: 1'b1};

  // Inputs carried by the port list but not needed by a read-only consumer.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, icb_wr_s, partial_sum_calc_over};

  // ---------------------------------------------------------------------------
  // Fetch FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Fetch FSM next-state and bus-facing outputs
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next      = state;
    load_bias_req   = 1'b0;
    cmd_valid       = 1'b0;
    icb_cmd_m       = '0;
    icb_cmd_m.read  = 1'b1;
    icb_cmd_m.len   = 8'd0;
    icb_cmd_m.size  = 2'b10;
    icb_cmd_m.addr  = 32'(base_q + (ch_idx << 2));

    unique case (state)
      ST_IDLE: begin
        if (need && free_slot && (ntiles != '0)) state_next = ST_REQ;
      end
      ST_REQ: begin
        load_bias_req = 1'b1;
        if (load_bias_granted) state_next = ST_CMD;
      end
      ST_CMD: begin
        cmd_valid = !lane_skip;
        if (lane_skip)                   state_next = last_lane ? ST_DONE : ST_CMD;
        else if (icb_cmd_s.cmd_ready)    state_next = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_fire) state_next = last_lane ? ST_DONE : ST_CMD;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      ST_DRAIN: begin
        if (rsp_fire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // A reconfiguration abandons the fetch; an accepted read still owes us a
    // response, which must be swallowed before the bus is reused.
    if (init_cfg) begin
      if (cmd_fire ||
          ((state == ST_RSP || state == ST_DRAIN) && !rsp_fire))
        state_next = ST_DRAIN;
      else
        state_next = ST_IDLE;
    end

    icb_cmd_m.valid = cmd_valid;
  end

  // Configuration latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need     <= 1'b0;
      cfg_done <= 1'b0;
      base_q   <= '0;
      m_q      <= '0;
      ntiles   <= '0;
    end else if (init_cfg) begin
      need     <= (bias_base != '0);
      cfg_done <= 1'b1;
      base_q   <= bias_base;
      m_q      <= m;
      ntiles   <= ntiles_calc;
    end
  end

  // Fetch bookkeeping: lane index, fetch tile index, write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e  <= '0;
      ft <= '0;
      wp <= '0;
    end else if (init_cfg) begin
      e  <= '0;
      ft <= '0;
      wp <= '0;
    end else begin
      unique case (state)
        ST_REQ:  if (load_bias_granted) e <= '0;
        ST_CMD:  if (lane_skip && !last_lane) e <= e + 1'b1;
        ST_RSP:  if (rsp_fire && !last_lane) e <= e + 1'b1;
        ST_DONE: begin
          wp <= ptr_inc(wp);
          ft <= (ft + REG_WIDTH'(1) == ntiles) ? '0 : ft + REG_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Slot storage: fetched words, zero for skipped lanes and error responses
  // NOTE: the slot array is reset because the block guarantees all-zero slots
  // out of reset; drop the reset branch only if that guarantee is relaxed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BUF; b++)
        for (int l = 0; l < SIZE; l++)
          slot_mem[b][l] <= '0;
    end else if (!init_cfg) begin
      if (state == ST_CMD && lane_skip)
        slot_mem[wp][e] <= '0;
      else if (state == ST_RSP && rsp_fire)
        slot_mem[wp][e] <= icb_rsp_s.err ? '0 : DATA_WIDTH'(icb_rsp_s.rdata);
    end
  end

  // Slot occupancy and read pointer; fill and pop never touch the same slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_full <= '0;
      rp        <= '0;
    end else if (init_cfg) begin
      slot_full <= '0;
      rp        <= '0;
    end else begin
      if (fill) slot_full[wp] <= 1'b1;
      if (pop) begin
        slot_full[rp] <= 1'b0;
        rp            <= ptr_inc(rp);
      end
    end
  end

  // Tile strobe edge detection and first-partial-sum flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d    <= 1'b0;
      over_d     <= 1'b0;
      first_flag <= 1'b1;
    end else begin
      start_d <= tile_calc_start;
      over_d  <= tile_calc_over;
      if (init_cfg || over_edge) first_flag <= 1'b1;
      else if (start_edge)       first_flag <= 1'b0;
    end
  end

  // Output vector: head slot on the first partial sum, zeros otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < SIZE; l++) data_out[l] <= '0;
    end else if (start_edge && !init_cfg) begin
      if (pop) data_out <= slot_mem[rp];
      else     for (int l = 0; l < SIZE; l++) data_out[l] <= '0;
    end
  end

  // Sticky error: bus error response or underflow, cleared by reconfiguration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bias_err <= 1'b0;
    else if (init_cfg) bias_err <= 1'b0;
    else if ((state == ST_RSP && rsp_fire && icb_rsp_s.err) || underflow)
      bias_err <= 1'b1;
  end

`ifdef BIAS_PREFETCH_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cycles  <= '0;
      perf_underflow_cnt <= '0;
    end else if (init_cfg) begin
      perf_fetch_cycles  <= '0;
      perf_underflow_cnt <= '0;
    end else begin
      if (state != ST_IDLE && perf_fetch_cycles != '1)
        perf_fetch_cycles <= perf_fetch_cycles + 1'b1;
      if (underflow && perf_underflow_cnt != '1)
        perf_underflow_cnt <= perf_underflow_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bias_prefetch_loader.sv
// tb_bias_prefetch_loader: directed bench for bias_prefetch_loader
// (SIZE=16, NUM_BUF=2). A small ICB slave returns 0xB0000000 | addr for
// every read, so lane l of tile t at base B reads B + (t*16 + l)*4.

module tb_bias_prefetch_loader;
  import bias_prefetch_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           init_cfg;
  logic [31:0]    bias_base;
  logic [31:0]    m;
  logic           load_bias_req;
  logic           load_bias_granted;
  icb_ext_cmd_m_t icb_cmd_m;
  icb_ext_cmd_s_t icb_cmd_s;
  icb_ext_wr_m_t  icb_wr_m;
  icb_ext_wr_s_t  icb_wr_s;
  icb_ext_rsp_s_t icb_rsp_s;
  icb_ext_rsp_m_t icb_rsp_m;
  logic           tile_calc_start;
  logic           partial_sum_calc_over;
  logic           tile_calc_over;
  logic           bias_valid;
  logic           bias_err;
  logic [31:0]    data_out [16];

  int total = 0;
  int bad   = 0;

  // ICB slave / arbiter model controls and command log
  logic        grant_en = 1'b1;
  logic        hold     = 1'b0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr;
  int          cmd_count = 0;
  logic [31:0] cmd_log [256];

  bias_prefetch_loader #(
    .SIZE(16), .DATA_WIDTH(32), .REG_WIDTH(32), .NUM_BUF(2)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .init_cfg              (init_cfg),
    .bias_base             (bias_base),
    .m                     (m),
    .load_bias_req         (load_bias_req),
    .load_bias_granted     (load_bias_granted),
    .icb_cmd_m             (icb_cmd_m),
    .icb_cmd_s             (icb_cmd_s),
    .icb_wr_m              (icb_wr_m),
    .icb_wr_s              (icb_wr_s),
    .icb_rsp_s             (icb_rsp_s),
    .icb_rsp_m             (icb_rsp_m),
    .tile_calc_start       (tile_calc_start),
    .partial_sum_calc_over (partial_sum_calc_over),
    .tile_calc_over        (tile_calc_over),
    .bias_valid            (bias_valid),
    .bias_err              (bias_err),
    .data_out              (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_init(input logic [31:0] base, input logic [31:0] mm);
    @(negedge clk);
    bias_base = base;
    m         = mm;
    init_cfg  = 1'b1;
    @(negedge clk);
    init_cfg  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    tile_calc_start = 1'b1;
    @(negedge clk);
    tile_calc_start = 1'b0;
  endtask

  task automatic pulse_psum();
    @(negedge clk);
    partial_sum_calc_over = 1'b1;
    @(negedge clk);
    partial_sum_calc_over = 1'b0;
  endtask

  task automatic pulse_over();
    @(negedge clk);
    tile_calc_over = 1'b1;
    @(negedge clk);
    tile_calc_over = 1'b0;
  endtask

  // Arbiter and ICB slave: one-cycle grant, response the cycle after accept
  initial begin
    icb_cmd_s         = '{cmd_ready: 1'b1};
    icb_wr_s          = '0;
    icb_rsp_s         = '0;
    load_bias_granted = 1'b0;
    forever begin
      @(negedge clk);
      load_bias_granted = load_bias_req && grant_en;
      icb_rsp_s = '0;
      if (pend && !hold) begin
        icb_rsp_s.rsp_valid = 1'b1;
        icb_rsp_s.rdata     = 32'hB000_0000 | pend_addr;
        icb_rsp_s.err       = (pend_addr == err_addr);
        pend = 1'b0;
      end
      if (icb_cmd_m.valid && icb_cmd_s.cmd_ready) begin
        pend      = 1'b1;
        pend_addr = icb_cmd_m.addr;
        if (cmd_count < 256) cmd_log[cmd_count] = icb_cmd_m.addr;
        cmd_count++;
      end
    end
  end

  initial begin
    int cnt_a;
    rst_n                 = 1'b0;
    init_cfg              = 1'b0;
    bias_base             = '0;
    m                     = '0;
    tile_calc_start       = 1'b0;
    partial_sum_calc_over = 1'b0;
    tile_calc_over        = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    // Reset state
    check("rst_data_out0",  data_out[0],  32'h0);
    check("rst_data_out15", data_out[15], 32'h0);
    check("rst_req",        32'(load_bias_req), 32'd0);
    check("rst_valid",      32'(bias_valid),    32'd0);
    check("rst_err",        32'(bias_err),      32'd0);

    // base=0x1000, m=40: tiles 0 and 1 fill both slots, third fetch waits
    do_init(32'h1000, 32'd40);
    wait_cycles(200);
    check("fill_valid",     32'(bias_valid),    32'd1);
    check("fill_cmd_count", cmd_count,          32'd32);
    check("fill_last_addr", cmd_log[31],        32'h107C);
    check("full_no_req",    32'(load_bias_req), 32'd0);
    check("fill_err",       32'(bias_err),      32'd0);

    // OA tile with 3 partial sums: vector, zeros, zeros
    pulse_start();
    for (int l = 0; l < 16; l++)
      check($sformatf("t0_lane%0d", l), data_out[l], 32'hB000_1000 + 32'(l * 4));
    pulse_psum();
    check("psum_hold_lane3", data_out[3], 32'hB000_100C);
    pulse_start();
    check("ps2_lane0",  data_out[0],  32'h0);
    check("ps2_lane15", data_out[15], 32'h0);
    pulse_psum();
    pulse_start();
    check("ps3_lane0", data_out[0], 32'h0);
    pulse_psum();
    pulse_over();

    // Tile 2 fetch: 8 real lanes 0x1080..0x109C, no bus cmd for lanes 8..15
    wait_cycles(100);
    check("t2_cmd_count", cmd_count,   32'd40);
    check("t2_first",     cmd_log[32], 32'h1080);
    check("t2_last",      cmd_log[39], 32'h109C);

    // Re-armed by tile_calc_over: next start pops tile 1
    pulse_start();
    check("t1_lane0",  data_out[0],  32'hB000_1040);
    check("t1_lane15", data_out[15], 32'hB000_107C);
    pulse_over();
    wait_cycles(100);
    check("wrap_cmd_count", cmd_count,   32'd56);
    check("wrap_addr",      cmd_log[40], 32'h1000);

    // Pop tile 2 with the arbiter withholding grants
    grant_en = 1'b0;
    pulse_start();
    check("t2_lane7", data_out[7], 32'hB000_109C);
    check("t2_lane8", data_out[8], 32'h0);
    pulse_over();
    wait_cycles(20);
    check("wait_grant_req", 32'(load_bias_req), 32'd1);
    check("wait_grant_cnt", cmd_count,          32'd56);

    // Pop wrapped tile 0, then underflow on an empty head
    pulse_start();
    check("wrap_t0_lane0", data_out[0], 32'hB000_1000);
    check("pre_uf_err",    32'(bias_err), 32'd0);
    pulse_over();
    pulse_start();
    check("uf_lane0", data_out[0],    32'h0);
    check("uf_err",   32'(bias_err),  32'd1);
    pulse_over();

    // Error response on element 5 of tile 0
    err_addr = 32'h1014;
    grant_en = 1'b1;
    do_init(32'h1000, 32'd40);
    wait_cycles(2);
    check("init_clears_err", 32'(bias_err), 32'd0);
    wait_cycles(200);
    check("rsp_err_sticky", 32'(bias_err),   32'd1);
    check("rsp_err_valid",  32'(bias_valid), 32'd1);
    pulse_start();
    check("err_lane4", data_out[4], 32'hB000_1010);
    check("err_lane5", data_out[5], 32'h0);
    check("err_lane6", data_out[6], 32'hB000_1018);
    pulse_over();
    err_addr = 32'hFFFF_FFFF;
    wait_cycles(100);

    // init_cfg while a read is outstanding: response drained, restart at tile 0
    hold  = 1'b1;
    cnt_a = cmd_count;
    do_init(32'h2000, 32'd16);
    wait_cycles(10);
    check("rsp_wait_count", cmd_count,          cnt_a + 1);
    check("rsp_wait_addr",  cmd_log[cnt_a],     32'h2000);
    check("rsp_wait_req",   32'(load_bias_req), 32'd0);
    do_init(32'h3000, 32'd16);
    wait_cycles(3);
    check("drain_valid", 32'(bias_valid), 32'd0);
    check("drain_count", cmd_count,       cnt_a + 1);
    cnt_a = cmd_count;
    hold  = 1'b0;
    wait_cycles(100);
    check("restart_addr",  cmd_log[cnt_a], 32'h3000);
    check("restart_count", cmd_count,      cnt_a + 32);
    check("restart_valid", 32'(bias_valid), 32'd1);
    check("restart_err",   32'(bias_err),   32'd0);
    pulse_start();
    check("new_lane0",  data_out[0],  32'hB000_3000);
    check("new_lane15", data_out[15], 32'hB000_303C);
    pulse_over();

    // Bias disabled: always valid, never requests, zeros on data_out
    do_init(32'h0, 32'd40);
    wait_cycles(5);
    cnt_a = cmd_count;
    wait_cycles(50);
    check("nobias_valid", 32'(bias_valid),    32'd1);
    check("nobias_req",   32'(load_bias_req), 32'd0);
    check("nobias_cmds",  cmd_count,          cnt_a);
    pulse_start();
    check("nobias_lane0", data_out[0],    32'h0);
    check("nobias_err",   32'(bias_err),  32'd0);
    pulse_over();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
